gfx_plane_shifter_sync: RTL and testbench



---
 rtl/gfx_plane_shifter_sync_pkg.sv | 25 ++
 rtl/cen_fall_det_sync.sv | 26 ++
 rtl/gfx_plane_shifter_sync.sv | 86 ++++++++
 tb/tb_gfx_plane_shifter_sync.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_plane_shifter_sync_pkg.sv
// Shared constants and helpers for the tile bitplane shifter and related
// Cen-edge TTL emulations.
package gfx_plane_shifter_sync_pkg;

    localparam int unsigned DEF_PLANES = 4;
    localparam int unsigned DEF_WIDTH  = 8;

    // What the plane bank does on a given clk cycle.
    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_LOAD,
        ACT_HOLD,
        ACT_SHIFT
    } shift_act_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cen_fall_det_sync.sv
// Detects a falling edge of the pixel clock enable Cen in the clk domain.
module cen_fall_det_sync (
    input  logic clk,
    input  logic VIDEO_RST,
    input  logic Cen,
    output logic ev
);

    logic last_cen;
    logic armed;

    // armed blocks the spurious edge that last_cen=1 out of reset would
    // otherwise create when Cen is already low at release.
    always_ff @(posedge clk) begin
        if (VIDEO_RST) begin
            last_cen <= 1'b1;
            armed    <= 1'b0;
        end else begin
            last_cen <= Cen;
            armed    <= armed | Cen;
        end
    end

    assign ev = armed & last_cen & ~Cen;

endmodule

// File: rtl/gfx_plane_shifter_sync.sv
// Bank of parallel-in/serial-out bitplane shifters turning a tile row-slice
// into one PLANES-bit pixel code per Cen falling edge.
module gfx_plane_shifter_sync
    import gfx_plane_shifter_sync_pkg::*;
#(
    parameter int unsigned PLANES = DEF_PLANES,
    parameter int unsigned WIDTH  = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     VIDEO_RST,
    input  logic                     Cen,
    input  logic                     LOAD,
    input  logic                     HOLD,
    input  logic                     FLIP,
    input  logic [PLANES*WIDTH-1:0]  D,
    output logic [PLANES-1:0]        Q,
    output logic                     VALID,
    output logic                     LAST
);

    localparam int unsigned     CW       = clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);

    logic           ev;
    shift_act_e     act;
    logic           flip_l;
    logic [CW-1:0]  cnt;

    cen_fall_det_sync u_cen_det (
        .clk       (clk),
        .VIDEO_RST (VIDEO_RST),
        .Cen       (Cen),
        .ev        (ev)
    );

    always_comb begin
        act = ACT_NONE;
        if (ev) begin
            if (LOAD)      act = ACT_LOAD;
            else if (HOLD) act = ACT_HOLD;
            else           act = ACT_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (VIDEO_RST) begin
            flip_l <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (act)
                ACT_LOAD: begin
                    flip_l <= FLIP;
                    cnt    <= CNT_FULL;
                end
                ACT_SHIFT: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    for (genvar p = 0; p < PLANES; p++) begin : g_plane
        logic [WIDTH-1:0] sr;

        // Zero fill on the trailing side makes an exhausted slice transparent.
        always_ff @(posedge clk) begin
            if (VIDEO_RST) begin
                sr <= '0;
            end else begin
                unique case (act)
                    ACT_LOAD:  sr <= D[p*WIDTH +: WIDTH];
                    ACT_SHIFT: sr <= flip_l ? {1'b0, sr[WIDTH-1:1]}
                                            : {sr[WIDTH-2:0], 1'b0};
                    default: ;
                endcase
            end
        end

        assign Q[p] = flip_l ? sr[0] : sr[WIDTH-1];
    end

    assign VALID = (cnt != '0);
    assign LAST  = (cnt == CW'(1));

endmodule

// File: tb/tb_gfx_plane_shifter_sync.sv
// Randomized self-checking bench for gfx_plane_shifter_sync against a
// pixel-index model of the loaded slice.
module tb_gfx_plane_shifter_sync;

    localparam int P  = 4;
    localparam int W  = 8;
    localparam int PW = P * W;

    logic          clk = 1'b0;
    logic          VIDEO_RST = 1'b0;
    logic          Cen = 1'b0;
    logic          LOAD = 1'b0;
    logic          HOLD = 1'b0;
    logic          FLIP = 1'b0;
    logic [PW-1:0] D = '0;
    logic [P-1:0]  Q;
    logic          VALID;
    logic          LAST;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the loaded slice, its flip, and which pixel is on show.
    logic [PW-1:0] m_d;
    bit            m_flip;
    int            m_idx;
    int            m_rem;

    gfx_plane_shifter_sync #(.PLANES(P), .WIDTH(W)) dut (
        .clk       (clk),
        .VIDEO_RST (VIDEO_RST),
        .Cen       (Cen),
        .LOAD      (LOAD),
        .HOLD      (HOLD),
        .FLIP      (FLIP),
        .D         (D),
        .Q         (Q),
        .VALID     (VALID),
        .LAST      (LAST)
    );

    always #5 clk = ~clk;

    function automatic logic [P-1:0] exp_q();
        logic [P-1:0] r;
        r = '0;
        if (m_rem > 0) begin
            for (int p = 0; p < P; p++)
                r[p] = m_flip ? m_d[p*W + m_idx] : m_d[p*W + (W-1-m_idx)];
        end
        return r;
    endfunction

    function automatic logic [P+1:0] exp_all();
        return {exp_q(), (m_rem != 0), (m_rem == 1)};
    endfunction

    task automatic model_reset();
        m_d = '0; m_flip = 0; m_idx = 0; m_rem = 0;
    endtask

    // One Cen high->low pulse with the given controls; model follows the event.
    task automatic pulse(input bit ld, input bit hd, input bit fl, input logic [PW-1:0] d);
        @(negedge clk);
        Cen = 1'b1; LOAD = ld; HOLD = hd; FLIP = fl; D = d;
        @(negedge clk);
        Cen = 1'b0;
        @(negedge clk);
        LOAD = 1'b0; HOLD = 1'b0;
        if (ld) begin
            m_d = d; m_flip = fl; m_idx = 0; m_rem = W;
        end else if (!hd && m_rem > 0) begin
            m_idx++; m_rem--;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        Cen = 1'b0; VIDEO_RST = 1'b1;
        @(negedge clk);
        VIDEO_RST = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({Q, VALID, LAST} !== {{P{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got Q=%b V=%b L=%b, want 0 0 0", Q, VALID, LAST);
        end
    endtask

    task automatic test_noflip();
        logic [8:0] seq;
        seq = 9'b110000010;
        pulse(1, 0, 0, 32'h0000_00C1);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) pulse(0, 0, 0, 32'h0);
            n_tests++;
            if ({Q, VALID, LAST} !== exp_all() || Q[0] !== seq[8-i]) begin
                n_fail++;
                $display("FAIL noflip px%0d: got Q=%b V=%b L=%b, want %b (Q0=%b)",
                         i, Q, VALID, LAST, exp_all(), seq[8-i]);
            end
        end
    endtask

    task automatic test_flip();
        logic [8:0] seq;
        seq = 9'b100000110;
        pulse(1, 0, 1, 32'h0000_00C1);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) pulse(0, 0, 0, 32'h0);
            n_tests++;
            if ({Q, VALID, LAST} !== exp_all() || Q[0] !== seq[8-i]) begin
                n_fail++;
                $display("FAIL flip px%0d: got Q=%b V=%b L=%b, want %b (Q0=%b)",
                         i, Q, VALID, LAST, exp_all(), seq[8-i]);
            end
        end
    endtask

    task automatic test_planes();
        pulse(1, 0, 0, {8'hFF, 8'h00, 8'hF0, 8'h0F});
        for (int i = 0; i < 8; i++) begin
            if (i > 0) pulse(0, 0, $urandom_range(0, 1), 32'h0);
            n_tests++;
            if ({Q, VALID, LAST} !== exp_all()) begin
                n_fail++;
                $display("FAIL planes px%0d: got %b, want %b", i, {Q, VALID, LAST}, exp_all());
            end
        end
    endtask

    task automatic test_back_to_back();
        pulse(1, 0, 0, $urandom);
        for (int i = 0; i < 7; i++) pulse(0, 0, 0, 32'h0);
        n_tests++;
        if (LAST !== 1'b1 || {Q, VALID, LAST} !== exp_all()) begin
            n_fail++;
            $display("FAIL b2b_last: got %b, want %b", {Q, VALID, LAST}, exp_all());
        end
        pulse(1, 0, 0, 32'h0000_0080);
        n_tests++;
        if (Q[0] !== 1'b1 || VALID !== 1'b1 || {Q, VALID, LAST} !== exp_all()) begin
            n_fail++;
            $display("FAIL b2b_seam: got %b, want %b", {Q, VALID, LAST}, exp_all());
        end
        for (int i = 0; i < 7; i++) pulse(0, 0, 0, 32'h0);
        pulse(1, 0, 1, $urandom);
        n_tests++;
        if ({Q, VALID, LAST} !== exp_all()) begin
            n_fail++;
            $display("FAIL b2b_flip: got %b, want %b", {Q, VALID, LAST}, exp_all());
        end
    endtask

    task automatic test_hold();
        pulse(1, 0, 0, $urandom);
        pulse(0, 0, 0, 32'h0);
        pulse(0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            pulse(0, 1, $urandom_range(0, 1), $urandom);
            n_tests++;
            if ({Q, VALID, LAST} !== exp_all()) begin
                n_fail++;
                $display("FAIL hold%0d: got %b, want %b", i, {Q, VALID, LAST}, exp_all());
            end
        end
        pulse(1, 1, 1, $urandom);
        n_tests++;
        if ({Q, VALID, LAST} !== exp_all()) begin
            n_fail++;
            $display("FAIL load_over_hold: got %b, want %b", {Q, VALID, LAST}, exp_all());
        end
    endtask

    task automatic test_random();
        bit ld, hd, fl;
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom % 5) == 0;
            hd = ($urandom % 4) == 0;
            fl = $urandom_range(0, 1);
            pulse(ld, hd, fl, $urandom);
            n_tests++;
            if ({Q, VALID, LAST} !== exp_all()) begin
                n_fail++;
                $display("FAIL random%0d ld=%0d hd=%0d: got %b, want %b",
                         i, ld, hd, {Q, VALID, LAST}, exp_all());
            end
        end
    endtask

    task automatic test_cen_idle();
        pulse(1, 0, 0, $urandom);
        pulse(0, 0, 0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            Cen = 1'b0; LOAD = $urandom_range(0, 1); D = $urandom;
            n_tests++;
            if ({Q, VALID, LAST} !== exp_all()) begin
                n_fail++;
                $display("FAIL cen_low%0d: got %b, want %b", i, {Q, VALID, LAST}, exp_all());
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            Cen = 1'b1; LOAD = $urandom_range(0, 1); D = $urandom;
            n_tests++;
            if ({Q, VALID, LAST} !== exp_all()) begin
                n_fail++;
                $display("FAIL cen_high%0d: got %b, want %b", i, {Q, VALID, LAST}, exp_all());
            end
        end
        LOAD = 1'b0;
        pulse(0, 0, 0, 32'h0);
        n_tests++;
        if ({Q, VALID, LAST} !== exp_all()) begin
            n_fail++;
            $display("FAIL cen_resume: got %b, want %b", {Q, VALID, LAST}, exp_all());
        end
    endtask

    task automatic test_reset_mid();
        pulse(1, 0, 0, 32'hFFFF_FFFF);
        pulse(0, 0, 0, 32'h0);
        @(negedge clk);
        VIDEO_RST = 1'b1; Cen = 1'b0; LOAD = 1'b1; D = 32'hFFFF_FFFF;
        @(negedge clk);
        VIDEO_RST = 1'b0;
        model_reset();
        n_tests++;
        if ({Q, VALID, LAST} !== exp_all()) begin
            n_fail++;
            $display("FAIL reset_mid: got %b, want %b", {Q, VALID, LAST}, exp_all());
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if ({Q, VALID, LAST} !== exp_all()) begin
                n_fail++;
                $display("FAIL post_reset_noev%0d: got %b, want %b", i, {Q, VALID, LAST}, exp_all());
            end
        end
        LOAD = 1'b0;
        pulse(1, 0, 0, 32'h8000_0000);
        n_tests++;
        if ({Q, VALID, LAST} !== exp_all()) begin
            n_fail++;
            $display("FAIL post_reset_load: got %b, want %b", {Q, VALID, LAST}, exp_all());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_noflip();
        test_flip();
        test_planes();
        test_back_to_back();
        test_hold();
        test_cen_idle();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
